// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-port word memory behind a request/acknowledge
//               handshake. A request is sampled only in IDLE. The block then
//               spends WAIT_STATES cycles in WAIT and completes in RESP with a
//               one-cycle registered ack. A write commits, or a read loads
//               rdata, on the edge that enters RESP.
//
// Parameters  : ADDR_W       word address width (depth = 2**ADDR_W words)
//               WAIT_STATES  wait cycles per access, 0..15
//
// Ports       : clock    in   1       system clock, rising edge
//               reset_n  in   1       synchronous active-low reset
//               req      in   1       access request, held until ack
//               we       in   1       1 = write, 0 = read
//               addr     in   ADDR_W  word address
//               wdata    in   16      write data
//               rdata    out  16      read data, held until the next read
//               ack      out  1       one-cycle completion pulse
//               busy     out  1       high whenever the FSM is not in IDLE
//               perr     out  1       parity error on the current read
//
// Build option: MEM_RESPONDER_PARITY_EN
//               defined   -> 17-bit words (data + even parity), perr live
//               undefined -> 16-bit words, perr tied to 0
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              perr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_DEPTH = 1 << ADDR_W;
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_STATES);
`ifdef MEM_RESPONDER_PARITY_EN
    localparam int          c_WORD_W = 17;
`else
    localparam int          c_WORD_W = 16;
`endif

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                w_accept;
    logic                w_enter_resp;

    // Request latched at acceptance
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [15:0]         r_wdata;

    // Access fields seen on the RESP-entry edge
    logic [ADDR_W-1:0]   w_acc_addr;
    logic                w_acc_we;
    logic [15:0]         w_acc_wdata;

    logic [c_WORD_W-1:0] r_mem [c_DEPTH];
    logic [c_WORD_W-1:0] w_wr_word;
    logic [c_WORD_W-1:0] w_rd_word;

    logic [15:0]         r_rdata;
    logic                r_ack;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and wait counter
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (c_WAIT == 4'd0) begin
                        // Zero wait states: complete straight from IDLE
                        w_next_state = S_RESP;
                        w_enter_resp = 1'b1;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_next_state = S_WAIT;
                        w_cnt_next   = c_WAIT;
                    end
                end
            end

            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                // Leave on the edge where the counter holds 1, giving exactly
                // WAIT_STATES cycles here. The <= also guards a stray zero.
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end

            S_RESP: begin
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Access fields. With zero wait states, RESP is entered from IDLE on the
    // acceptance edge itself, so the live inputs must be used because the
    // latches are not yet loaded.
    // ------------------------------------------------------------------------
    always_comb begin
        w_acc_addr  = r_addr;
        w_acc_we    = r_we;
        w_acc_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_acc_addr  = addr;
            w_acc_we    = we;
            w_acc_wdata = wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Request latches (data only, no reset needed)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Storage word format and read port
    // ------------------------------------------------------------------------
`ifdef MEM_RESPONDER_PARITY_EN
    // Store the data with its even-parity bit in the MSB
    assign w_wr_word = {^w_acc_wdata, w_acc_wdata};
`else
    assign w_wr_word = w_acc_wdata;
`endif

    assign w_rd_word = r_mem[w_acc_addr];

    // ------------------------------------------------------------------------
    // Memory array. Contents survive reset. A reset on the commit edge still
    // blocks the write, so an access aborted in WAIT never lands.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset_n && w_enter_resp && w_acc_we) begin
            r_mem[w_acc_addr] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------------
    // Wait counter, ack pulse and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            r_cnt <= w_cnt_next;
            // ack is high for exactly the cycle spent in RESP
            r_ack <= w_enter_resp;
            if (w_enter_resp && !w_acc_we) begin
                r_rdata <= w_rd_word[15:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Parity error flag
    // ------------------------------------------------------------------------
`ifdef MEM_RESPONDER_PARITY_EN
    logic r_perr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perr <= 1'b0;
        end else begin
            // Clear when a new read is accepted; a completion on the same
            // edge (zero wait states) overrides with the fresh result.
            if (w_accept && !we) begin
                r_perr <= 1'b0;
            end
            if (w_enter_resp && !w_acc_we) begin
                // Odd parity across all 17 stored bits means corruption
                r_perr <= ^w_rd_word;
            end
        end
    end

    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock and reset_n.
REQ-002 Parameter ADDR_W SHALL default to 8 and set the word address width; depth is 2^ADDR_W words.
REQ-003 Parameter WAIT_STATES SHALL default to 1 and set the number of wait cycles per access (legal range 0..15).
REQ-004 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  synchronous active-low reset.
REQ-006 Port req  input  1  access request from the execution unit; held with addr/we/wdata until ack.
REQ-007 Port we  input  1  1 = write, 0 = read.
REQ-008 Port addr  input  ADDR_W  word address.
REQ-009 Port wdata  input  16  write data.
REQ-010 Port rdata  output  16  read data; valid in the ack cycle and held until the next read completes.
REQ-011 Port ack  output  1  registered one-cycle completion pulse.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port perr  output  1  parity error flag for the current read (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP; busy = (state != IDLE).
REQ-015 In IDLE with req=1, the block SHALL latch addr, we and wdata, load the wait counter with WAIT_STATES, and go to WAIT, or go directly to RESP if WAIT_STATES=0.
REQ-016 In IDLE, req SHALL be sampled only in this state; req changes in WAIT/RESP SHALL be ignored.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 1 (exactly WAIT_STATES cycles in WAIT).
REQ-018 On entry to RESP (the same edge), a write SHALL commit the latched wdata to the latched address, and a read SHALL load rdata from the latched address.
REQ-019 In RESP, ack SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-020 Latency: ack SHALL be high in cycle 2+WAIT_STATES, counting the IDLE cycle in which req is sampled as cycle 1.
REQ-021 If req is still high in IDLE after RESP, it SHALL be accepted as a new access; the minimum spacing between accepted requests is 2+WAIT_STATES cycles.
REQ-022 A read of a location written earlier SHALL return the last committed value.
REQ-023 A write SHALL leave rdata unchanged.
REQ-024 Addresses SHALL cover the full 2^ADDR_W range, with no out-of-range case and no wrap logic.

Reset
REQ-025 While reset_n=0 at a clock edge: state=IDLE, ack=0, rdata=16'h0000, perr=0, wait counter=0.
REQ-026 Memory array contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted while in WAIT SHALL abort the access with no write commit and no ack.
REQ-028 Reset asserted in the RESP cycle SHALL force ack=0 on the following cycle; a write already committed on RESP entry stays committed.

Configuration
REQ-029 Macro MEM_RESPONDER_PARITY_EN SHALL control parity support.
REQ-030 With MEM_RESPONDER_PARITY_EN defined, each word SHALL be stored as 17 bits: data plus even parity (XOR of the 16 data bits) computed on write.
REQ-031 With MEM_RESPONDER_PARITY_EN defined, a read SHALL set perr=1 in the ack cycle if the stored 17 bits have odd parity, and clear perr on the next accepted read.
REQ-032 With MEM_RESPONDER_PARITY_EN undefined, storage SHALL be 16 bits and perr SHALL be tied to 0.

Verification
REQ-033 Reset with reset_n=0 for 2 cycles -> ack=0, busy=0, rdata=0000, perr=0.
REQ-034 WAIT_STATES=1: write addr=8'h05, wdata=16'hA5C3, then read addr=8'h05 -> rdata=A5C3; ack in cycle 3 of each access; busy high for 2 cycles per access.
REQ-035 WAIT_STATES=0: req held high for back-to-back reads of 8'h00 and 8'hFF -> one ack every 2 cycles; rdata matches prior writes of 1234 and FFFF.
REQ-036 Write 16'h1111 to 8'h10, then assert reset_n=0 during WAIT of a write of 16'h2222 to 8'h10, then read 8'h10 -> 1111; no ack during the aborted access.
REQ-037 req dropped during WAIT -> access still completes with ack and write committed.
REQ-038 With MEM_RESPONDER_PARITY_EN defined: write 16'h0001, force the stored parity bit to 0 via hierarchical deposit, read -> perr=1 in the ack cycle; a subsequent clean read -> perr=0.
